sequence_tx: RTL
================

SEQUENCE_TX -- requirements
Module: sequence_tx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the number of payload bits per frame (legal range 1..32).
REQ-002 The block SHALL have parameter GAP, default 2, meaning the number of idle-low cycles after each frame's payload (legal range 0..15).
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, the reset; it is asynchronous and active-low.
REQ-005 The block SHALL have port start, input, 1 bit, a frame request sampled on the rising edge of clk.
REQ-006 The block SHALL have port data, input, WIDTH bits, the payload captured when a request is accepted.
REQ-007 The block SHALL have port aout, output, 1 bit, the registered serial line to the downstream edge-detecting receiver.
REQ-008 The block SHALL have port busy, output, 1 bit, high while a frame (start bit, payload or gap) is in progress.
REQ-009 The block SHALL have port done, output, 1 bit, a single-cycle pulse marking frame completion.

Function
REQ-010 The FSM SHALL have states IDLE, STARTBIT, SHIFT and GAPWAIT, with all outputs driven from registers (no combinational path from start or data to aout).
REQ-011 In IDLE, a start sampled high SHALL be accepted: data is latched into a WIDTH-bit shift register and the next state is STARTBIT.
REQ-012 STARTBIT SHALL last exactly one cycle with aout=1, so the receiver sees a 0->1 edge from the idle-low line.
REQ-013 SHIFT SHALL last exactly WIDTH cycles, driving aout with the latched payload MSB first, one bit per cycle.
REQ-014 After the last payload bit, GAPWAIT SHALL last exactly GAP cycles with aout=0; when GAP=0, GAPWAIT is skipped and the next state is IDLE.
REQ-015 busy SHALL be 1 in STARTBIT, SHIFT and GAPWAIT, and 0 in IDLE, so one frame occupies exactly 1+WIDTH+GAP cycles of busy.
REQ-016 done SHALL be 1 for exactly the first IDLE cycle following a frame, with busy=0 in that same cycle.
REQ-017 aout SHALL be 0 in IDLE.
REQ-018 A start asserted while busy=1 SHALL be ignored: it is not queued and does not alter the frame in progress.
REQ-019 A start asserted in the cycle where done=1 SHALL be accepted, which allows back-to-back frames separated only by that one IDLE cycle.
REQ-020 Changes on data after acceptance SHALL NOT affect the frame in progress.
REQ-021 The bit counter SHALL be sized to hold max(WIDTH,GAP) and SHALL NOT wrap within a frame.
REQ-022 If start is held high continuously, a new frame SHALL begin on every IDLE cycle, i.e. with a period of 2+WIDTH+GAP cycles.

Reset
REQ-023 While reset=0, the block SHALL hold state=IDLE, aout=0, busy=0, done=0, and the shift register and counter at 0, regardless of clk.
REQ-024 Reset asserted mid-frame SHALL abort the frame immediately (asynchronously): aout falls to 0, and no done pulse is produced for the aborted frame.
REQ-025 On the first rising edge of clk after reset is released, the block SHALL be in IDLE and able to accept start.

Verification
REQ-026 The bench SHALL cover: WIDTH=8, GAP=2, data=8'hA5, one start pulse -> aout = 1,1,0,1,0,0,1,0,1,0,0 over 11 cycles with busy=1, then done=1 and busy=0 for one cycle.
REQ-027 The bench SHALL cover: start held high for 30 cycles, WIDTH=8, GAP=2 -> frames begin every 12 cycles, with exactly one done pulse per frame.
REQ-028 The bench SHALL cover: a second start issued during the SHIFT of the first frame with a different data value -> the second request is ignored, only one frame and one done occur, and the payload is unchanged.
REQ-029 The bench SHALL cover: reset driven low during the 4th payload bit, asynchronous to clk -> aout=0 and busy=0 immediately, with no done pulse; a start after release sends a complete fresh frame.
REQ-030 The bench SHALL cover: WIDTH=4, GAP=0, data=4'h0 -> aout = 1,0,0,0,0 with busy high for 5 cycles, then done on the next cycle.
REQ-031 The bench SHALL cover: loopback of aout into the existing rising-edge detector -> exactly one detector pulse per frame start bit, plus one per isolated 0->1 transition in the payload.

Source files
------------

// File: rtl/sequence_tx.sv
// Serial frame transmitter: idle-low line, one high start bit, WIDTH payload bits MSB first,
// then GAP idle-low cycles. Outputs are registered.
//
// state    | meaning
// IDLE     | line low, waiting for start (done pulses here after a frame)
// STARTBIT | line high for one cycle to give the receiver a rising edge
// SHIFT    | payload bits on the line, MSB first
// GAPWAIT  | line low, still busy, before returning to IDLE
module sequence_tx #(
    parameter int WIDTH = 8,
    parameter int GAP   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    output logic             aout,
    output logic             busy,
    output logic             done
);

    localparam int MAXV = (WIDTH > GAP) ? WIDTH : GAP;
    localparam int CW   = $clog2(MAXV + 1);

    typedef enum logic [1:0] {IDLE, STARTBIT, SHIFT, GAPWAIT} state_t;

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;

    // cnt holds the number of cycles still to run in the current state after this one
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
            aout  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sreg  <= data;
                        state <= STARTBIT;
                        aout  <= 1'b1;
                        busy  <= 1'b1;
                    end else begin
                        aout <= 1'b0;
                        busy <= 1'b0;
                    end
                end
                STARTBIT: begin
                    state <= SHIFT;
                    aout  <= sreg[WIDTH-1];
                    sreg  <= sreg << 1;
                    cnt   <= CW'(WIDTH - 1);
                end
                SHIFT: begin
                    if (cnt != '0) begin
                        aout <= sreg[WIDTH-1];
                        sreg <= sreg << 1;
                        cnt  <= cnt - 1'b1;
                    end else if (GAP == 0) begin
                        state <= IDLE;
                        aout  <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state <= GAPWAIT;
                        aout  <= 1'b0;
                        cnt   <= CW'(GAP - 1);
                    end
                end
                GAPWAIT: begin
                    aout <= 1'b0;
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    aout  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
